vga_sync_timing: RTL and testbench

- Consumes the fast system clock and sits directly downstream of the clock-scaling stage.
- Derives a pixel-rate enable internally rather than a divided clock, so the whole block stays on one clock domain.
- Generates VGA horizontal/vertical timing (hsync, vsync, active-video flag, pixel coordinates, frame/line markers) for the downstream pixel/colour logic.
- Defaults give 640x480@60 from a 50 MHz clock, with CLK_DIV=2 yielding 25 MHz pixel ticks.

---
 rtl/vga_sync_timing.sv | 161 ++++++++++++++++
 tb/tb_vga_sync_timing.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA horizontal/vertical timing generator running on the
// fast system clock. A prescaler produces a one-clk pixel-rate enable
// (pix_tick) so everything stays in the clk domain. Horizontal and vertical
// counters advance on pix_tick; sync, blanking and coordinates are decoded
// combinationally from the registered counters.
//
// Optional build macro VGA_TEST_PATTERN_EN adds a 12-bit rgb output that
// draws eight vertical colour bars across the active area.

module vga_sync_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0] rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);

    // Counters are 10 bits wide and the prescaler 4 bits, so reject
    // configurations that would not fit.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_param_check
        $error("vga_sync_timing: totals must be <= 1024 and CLK_DIV in 1..16");
    end

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_act;
    logic       vs_act;

    // Pixel-rate enable: last prescaler count while running.
    always_comb begin
        pix_tick = enable && (div_cnt == DIV_LAST);
    end

    // Prescaler counts 0..CLK_DIV-1 and holds while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    // Next raster position; h and v wrap together at the end of the frame.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Raster counters step only on pixel ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Sync, blanking, coordinates and line/frame markers from the counters.
    always_comb begin
        hs_act      = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
        vs_act      = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);
        hsync       = hs_act ? SYNC_ON : ~SYNC_ON;
        vsync       = vs_act ? SYNC_ON : ~SYNC_ON;
        video_on    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        x           = h_cnt;
        y           = v_cnt;
        line_start  = pix_tick && (h_cnt == 10'd0);
        frame_start = pix_tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [11:0] bar_colour(input logic [9:0] hx, input logic [9:0] vy);
        logic [2:0]  idx;
        logic [11:0] c;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hx >= 10'(i * BAR_W)) begin
                idx = 3'(i);
            end
        end
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        if ((hx >= H_ACT_END) || (vy >= V_ACT_END)) begin
            c = 12'h000;
        end
        return c;
    endfunction

    // Colour is registered from the next position so it lines up with x/y
    // after each tick and still comes out of reset as black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (pix_tick) begin
            rgb <= bar_colour(h_next, v_next);
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
// tb_vga_sync_timing: directed bench for vga_sync_timing. Horizontal timing
// uses the 640x480 defaults; the vertical timing is shortened (17 lines per
// frame, vsync on lines 14..15) so a complete frame fits a short run.

module tb_vga_sync_timing;

    localparam int LINE_CLKS  = 800 * 2;
    localparam int FRAME_CLKS = 17 * LINE_CLKS;
    localparam int BUDGET     = 40000;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_timing #(
        .CLK_DIV (2),
        .H_ACTIVE(640),
        .H_FP    (16),
        .H_SYNC  (96),
        .H_BP    (48),
        .V_ACTIVE(12),
        .V_FP    (2),
        .V_SYNC  (2),
        .V_BP    (1),
        .SYNC_POL(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_tick   (pix_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb        (rgb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int tx, input int ty, input string tag);
        int n;
        n = 0;
        while (!(int'(x) == tx && int'(y) == ty) && n < BUDGET) begin
            tick();
            n++;
        end
        check(tag, 32'(int'(x) == tx && int'(y) == ty), 32'd1);
    endtask

    initial begin
        int hs_low, hs_min, hs_max, vo_cnt, vo_fall, ls_cnt;
        int vs_low, vs_min, vs_max, cnt, px, py, wrap_px, wrap_py, wrap_x;
        int bad;
        logic [9:0] fx, fy;
        logic       fh;

        rst_n  = 1'b0;
        enable = 1'b1;
        #22;
        check("rst_pix_tick", 32'(pix_tick), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_video_on", 32'(video_on), 32'd1);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_line_start", 32'(line_start), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
        check("rst_rgb", 32'(rgb), 32'h000);
`endif
        #8;
        rst_n = 1'b1;

        // First ticks after release: every second clk, first one marks the frame.
        tick();
        check("t1_pix_tick", 32'(pix_tick), 32'd1);
        check("t1_frame_start", 32'(frame_start), 32'd1);
        check("t1_line_start", 32'(line_start), 32'd1);
        check("t1_x", 32'(x), 32'd0);
        tick();
        check("t2_pix_tick", 32'(pix_tick), 32'd0);
        check("t2_x", 32'(x), 32'd1);
        tick();
        check("t3_pix_tick", 32'(pix_tick), 32'd1);
        check("t3_frame_start", 32'(frame_start), 32'd0);
        tick();
        check("t4_x", 32'(x), 32'd2);

        // One full line starting at (0,1).
        wait_pos(0, 1, "wait_line1");
        hs_low = 0; hs_min = 9999; hs_max = -1; vo_cnt = 0; vo_fall = -1; ls_cnt = 0;
        for (int i = 0; i < LINE_CLKS; i++) begin
            if (hsync == 1'b0) begin
                hs_low++;
                if (int'(x) < hs_min) hs_min = int'(x);
                if (int'(x) > hs_max) hs_max = int'(x);
            end
            if (video_on) vo_cnt++;
            else if (vo_fall < 0) vo_fall = int'(x);
            if (line_start) ls_cnt++;
            tick();
        end
        check("line_hs_low_clks", 32'(hs_low), 32'd192);
        check("line_hs_first_x", 32'(hs_min), 32'd656);
        check("line_hs_last_x", 32'(hs_max), 32'd751);
        check("line_video_clks", 32'(vo_cnt), 32'd1280);
        check("line_video_fall_x", 32'(vo_fall), 32'd640);
        check("line_start_count", 32'(ls_cnt), 32'd1);
        check("line_end_x", 32'(x), 32'd0);
        check("line_end_y", 32'(y), 32'd2);

`ifdef VGA_TEST_PATTERN_EN
        wait_pos(0, 5, "wait_rgb0");
        check("rgb_x0", 32'(rgb), 32'hFFF);
        wait_pos(80, 5, "wait_rgb80");
        check("rgb_x80", 32'(rgb), 32'hFF0);
        wait_pos(320, 5, "wait_rgb320");
        check("rgb_x320", 32'(rgb), 32'hF0F);
        wait_pos(560, 5, "wait_rgb560");
        check("rgb_x560", 32'(rgb), 32'h000);
        wait_pos(650, 5, "wait_rgb650");
        check("rgb_x650", 32'(rgb), 32'h000);
`endif

        // Hold for 100 clks at (300,10), then resume without skipping.
        wait_pos(300, 10, "wait_hold");
        enable = 1'b0;
        fx = x; fy = y; fh = hsync;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (pix_tick || line_start || frame_start || x != fx || y != fy || hsync != fh) bad++;
            tick();
        end
        check("hold_violations", 32'(bad), 32'd0);
        check("hold_x", 32'(x), 32'd300);
        check("hold_y", 32'(y), 32'd10);
        check("hold_hsync", 32'(hsync), 32'd1);
        check("hold_video_on", 32'(video_on), 32'd1);
        enable = 1'b1;
        tick();
        check("resume1_x", 32'(x), 32'd300);
        check("resume1_tick", 32'(pix_tick), 32'd1);
        tick();
        check("resume2_x", 32'(x), 32'd301);
        check("resume2_tick", 32'(pix_tick), 32'd0);
        tick();
        tick();
        check("resume4_x", 32'(x), 32'd302);

        // Asynchronous reset while both syncs are active.
        wait_pos(700, 15, "wait_rst_pos");
        check("pre_rst_hsync", 32'(hsync), 32'd0);
        check("pre_rst_vsync", 32'(vsync), 32'd0);
        rst_n = 1'b0;
        #2;
        check("arst_x", 32'(x), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_vsync", 32'(vsync), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
        check("arst_rgb", 32'(rgb), 32'h000);
`endif
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_tick", 32'(pix_tick), 32'd1);
        check("post_rst_frame_start", 32'(frame_start), 32'd1);

        // Full frame from this frame_start to the next.
        cnt = 0; vs_low = 0; vs_min = 9999; vs_max = -1;
        px = 0; py = 0; wrap_px = -1; wrap_py = -1; wrap_x = -1;
        do begin
            tick();
            cnt++;
            if (vsync == 1'b0) begin
                vs_low++;
                if (int'(y) < vs_min) vs_min = int'(y);
                if (int'(y) > vs_max) vs_max = int'(y);
            end
            if (int'(x) != px || int'(y) != py) begin
                if (y == 10'd0 && py != 0) begin
                    wrap_px = px; wrap_py = py; wrap_x = int'(x);
                end
                px = int'(x); py = int'(y);
            end
        end while (!frame_start && cnt < BUDGET);
        check("frame_period", 32'(cnt), 32'(FRAME_CLKS));
        check("frame_vs_low_clks", 32'(vs_low), 32'd3200);
        check("frame_vs_first_y", 32'(vs_min), 32'd14);
        check("frame_vs_last_y", 32'(vs_max), 32'd15);
        check("wrap_from_x", 32'(wrap_px), 32'd799);
        check("wrap_from_y", 32'(wrap_py), 32'd16);
        check("wrap_to_x", 32'(wrap_x), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
